// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data ports, one transaction at a time.
// Define ARB_FAIRNESS_EN to force a fetch grant after MAX_STARVE consecutive data wins over a waiting fetch.
module mem_port_arbiter #(
   parameter int AW         = 12,
   parameter int MEM_LAT    = 1,
   parameter int MAX_STARVE = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [31:0]   if_rdata,
   output logic          if_ready,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [3:0]    dm_be,
   input  logic [AW-1:0] dm_addr,
   input  logic [31:0]   dm_wdata,
   output logic [31:0]   dm_rdata,
   output logic          dm_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-3:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          busy,
   output logic          owner
);
   localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          owner_q, owner_d, we_q, we_d;
   logic [3:0]    be_q, be_d;
   logic [AW-3:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic          if_ready_q, if_ready_d, dm_ready_q, dm_ready_d, busy_q, busy_d;
   logic          grant_data;
   logic          unused_addr_lsbs;

   assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

`ifdef ARB_FAIRNESS_EN
   logic [3:0] starve_q, starve_d;
   assign grant_data = dm_req && !(if_req && starve_q == 4'(MAX_STARVE));
   always_comb starve_d = (state_q == S_IDLE && (dm_req || if_req)) ? (grant_data ? starve_q + {3'b0, if_req} : 4'd0) : starve_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) starve_q <= 4'd0;
      else     starve_q <= starve_d;
`else
   assign grant_data = dm_req;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      case (state_q)
         S_IDLE: if (dm_req || if_req) begin
            state_d = S_ISSUE;
            owner_d = grant_data;
            we_d    = grant_data && dm_we;
            be_d    = dm_be;
            addr_d  = grant_data ? dm_addr[AW-1:2] : if_addr[AW-1:2];
            if (grant_data) wdata_d = dm_wdata;
         end
         S_ISSUE: begin
            cnt_d   = 4'(MEM_LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: if (cnt_q == 4'd0) begin
            state_d = S_DONE;
            if (!owner_q) if_rdata_d = mem_rdata;
            else if (!we_q) dm_rdata_d = mem_rdata;
         end else cnt_d = cnt_q - 4'd1;
         default: state_d = S_IDLE;
      endcase
   end

   // every output is registered, so strobes are derived from the next state
   assign mem_en_d   = state_d == S_ISSUE;
   assign mem_we_d   = mem_en_d && we_d;
   assign mem_be_d   = !mem_en_d ? 4'h0 : we_d ? be_d : 4'hF;
   assign if_ready_d = state_d == S_DONE && !owner_q;
   assign dm_ready_d = state_d == S_DONE && owner_q;
   assign busy_d     = state_d != S_IDLE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= 4'h0;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         if_rdata_q <= 32'h0;
         dm_rdata_q <= 32'h0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_be_q   <= 4'h0;
         if_ready_q <= 1'b0;
         dm_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         mem_en_q   <= mem_en_d;
         mem_we_q   <= mem_we_d;
         mem_be_q   <= mem_be_d;
         if_ready_q <= if_ready_d;
         dm_ready_q <= dm_ready_d;
         busy_q     <= busy_d;
      end

   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_ready  = dm_ready_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;
   assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and a random run against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int LAT = 1, MS = 4;

   typedef struct {
      bit          is_d;
      bit          we;
      bit          pre_en;
      logic [3:0]  be;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] pre;
      logic [9:0]  e_maddr;
      logic        e_mwe;
      logic [3:0]  e_mbe;
      logic [31:0] e_rdata;
      logic [31:0] e_mem;
   } vec_t;

   logic        clk = 1'b0, rst;
   logic        if_req, dm_req, dm_we;
   logic [11:0] if_addr, dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic        if_ready, dm_ready, mem_en, mem_we, busy, owner;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;

   logic        if_req3, if_ready3, dm_ready3, mem_en3, mem_we3, busy3, owner3;
   logic [11:0] if_addr3;
   logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
   logic [3:0]  mem_be3;
   logic [9:0]  mem_addr3;

   logic        pl_en;
   logic [9:0]  pl_addr;
   logic [31:0] pl_data;
   logic [31:0] mem [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic [31:0] word_q;
   logic [3:0]  lat_q;

   int          n_chk = 0, n_fail = 0;
   vec_t        vecs [8];
   vec_t        mr;
   logic [31:0] e2, e3, e_if, e_dm, g_rd, g_wdata;
   logic [9:0]  g_addr;
   logic [3:0]  g_be;
   int          n, g_cyc, next_free, starve;
   bit          exp_d, act, g_d, g_we, rdy, force_f, if_p, dm_p, e_own;

   mem_port_arbiter #(.AW(12), .MEM_LAT(LAT), .MAX_STARVE(MS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.AW(12), .MEM_LAT(3), .MAX_STARVE(MS)) dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ready(if_ready3),
      .dm_req(1'b0), .dm_we(1'b0), .dm_be(4'h0), .dm_addr(12'h0), .dm_wdata(32'h0),
      .dm_rdata(dm_rdata3), .dm_ready(dm_ready3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return 32'h1357_9BDF ^ (32'(i) * 32'h9E37_79B9);
   endfunction

   // memory macro: read data is valid for exactly LAT cycles after the access edge, junk otherwise
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
         lat_q <= 4'd0;
      end else begin
         if (pl_en) mem[pl_addr] <= pl_data;
         if (mem_en) begin
            word_q <= mem[mem_addr];
            lat_q  <= 4'd1;
            if (mem_we)
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else if (lat_q != 4'd0 && lat_q != 4'hF) lat_q <= lat_q + 4'd1;
      end
   end
   assign mem_rdata = (lat_q == 4'(LAT)) ? word_q : 32'hBAD0_BAD0;

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_chk++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act_v, exp_v);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_if_rdata"}, if_rdata, 32'h0);
      chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
      chk({tag, "_if_ready"}, 32'(if_ready), 32'h0);
      chk({tag, "_dm_ready"}, 32'(dm_ready), 32'h0);
      chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
      chk({tag, "_mem_be"}, 32'(mem_be), 32'h0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_owner"}, 32'(owner), 32'h0);
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      pl_en = v.pre_en; pl_addr = v.addr[11:2]; pl_data = v.pre;
      if (v.is_d) begin
         dm_req = 1'b1; dm_we = v.we; dm_be = v.be; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         pl_en = 1'b0;
         chk("vec_mem_en", 32'(mem_en), 32'(k == 1));
         chk("vec_busy", 32'(busy), 32'(k <= 3));
         chk("vec_if_ready", 32'(if_ready), 32'(k == 3 && !v.is_d));
         chk("vec_dm_ready", 32'(dm_ready), 32'(k == 3 && v.is_d));
         if (k == 1) begin
            chk("vec_mem_addr", 32'(mem_addr), 32'(v.e_maddr));
            chk("vec_mem_we", 32'(mem_we), 32'(v.e_mwe));
            chk("vec_mem_be", 32'(mem_be), 32'(v.e_mbe));
            chk("vec_owner", 32'(owner), 32'(v.is_d));
            if (v.is_d && v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
         end
         if (k == 3) begin
            chk("vec_rdata", v.is_d ? dm_rdata : if_rdata, v.e_rdata);
            if_req = 1'b0; dm_req = 1'b0;
         end
      end
      chk("vec_mem_word", mem[v.addr[11:2]], v.e_mem);
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
      if_addr = 12'h0; dm_addr = 12'h0; dm_wdata = 32'h0; pl_en = 1'b0; pl_addr = 10'h0; pl_data = 32'h0;
      if_req3 = 1'b0; if_addr3 = 12'h0; mem_rdata3 = 32'h0;
      vecs[0] = '{1'b0, 1'b0, 1'b1, 4'h0, 12'h010, 32'h0, 32'h0000_0013, 10'h004, 1'b0, 4'hF, 32'h0000_0013, 32'h0000_0013};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 4'h3, 12'h024, 32'hDEAD_BEEF, 32'h1122_3344, 10'h009, 1'b1, 4'h3, 32'h0, 32'h1122_BEEF};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 12'h027, 32'h0, 32'h0, 10'h009, 1'b0, 4'hF, 32'h1122_BEEF, 32'h1122_BEEF};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 4'h0, 12'h100, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 10'h040, 1'b1, 4'h0, 32'h1122_BEEF, 32'hA5A5_A5A5};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 4'h0, 12'hFFE, 32'h0, 32'h89AB_CDEF, 10'h3FF, 1'b0, 4'hF, 32'h89AB_CDEF, 32'h89AB_CDEF};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 4'hF, 12'h004, 32'h0102_0304, 32'h0, 10'h001, 1'b1, 4'hF, 32'h1122_BEEF, 32'h0102_0304};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 4'h8, 12'h006, 32'hAABB_CCDD, 32'h0, 10'h001, 1'b1, 4'h8, 32'h1122_BEEF, 32'hAA02_0304};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 12'h005, 32'h0, 32'h0, 10'h001, 1'b0, 4'hF, 32'hAA02_0304, 32'hAA02_0304};
      mr      = '{1'b0, 1'b0, 1'b1, 4'h0, 12'h030, 32'h0, 32'h5555_AAAA, 10'h00C, 1'b0, 4'hF, 32'h5555_AAAA, 32'h5555_AAAA};

      repeat (2) @(negedge clk);
      check_zero("rst_hold");
      rst = 1'b0;
      @(negedge clk);
      check_zero("rst_post");
      chk("rst_busy3", 32'(busy3), 32'h0);

      // MEM_LAT=3 instance: only the last WAIT cycle carries good read data
      if_req3 = 1'b1; if_addr3 = 12'h043;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         mem_rdata3 = (k == 4) ? 32'hCAFE_F00D : (32'hBAD0_0000 | 32'(k));
         chk("l3_mem_en", 32'(mem_en3), 32'(k == 1));
         chk("l3_busy", 32'(busy3), 32'(k <= 5));
         chk("l3_if_ready", 32'(if_ready3), 32'(k == 5));
         chk("l3_dm_ready", 32'(dm_ready3), 32'h0);
         if (k == 1) begin
            chk("l3_mem_addr", 32'(mem_addr3), 32'h010);
            chk("l3_mem_we", 32'(mem_we3), 32'h0);
            chk("l3_mem_be", 32'(mem_be3), 32'hF);
            chk("l3_owner", 32'(owner3), 32'h0);
         end
         if (k == 5) begin
            chk("l3_if_rdata", if_rdata3, 32'hCAFE_F00D);
            if_req3 = 1'b0;
         end
      end
      chk("l3_mem_wdata", mem_wdata3, 32'h0);
      chk("l3_dm_rdata", dm_rdata3, 32'h0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      e2 = mem[2]; e3 = mem[3];
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h008; if_req = 1'b1; if_addr = 12'h00C;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("sim_dm_ready", 32'(dm_ready), 32'(k == 3));
         chk("sim_if_ready", 32'(if_ready), 32'(k == 7));
         if (k == 1) chk("sim_owner_d", 32'(owner), 32'h1);
         if (k == 5) chk("sim_owner_f", 32'(owner), 32'h0);
         if (k == 3) begin chk("sim_dm_rdata", dm_rdata, e2); dm_req = 1'b0; end
         if (k == 7) begin chk("sim_if_rdata", if_rdata, e3); if_req = 1'b0; end
      end

      if_req = 1'b1; if_addr = 12'h010;
      @(negedge clk);
      chk("mr_mem_en", 32'(mem_en), 32'h1);
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0;
      #1 check_zero("mr");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mr_if_ready", 32'(if_ready), 32'h0);
         chk("mr_busy", 32'(busy), 32'h0);
      end
      run_vec(mr);

      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h000; if_req = 1'b1; if_addr = 12'h004;
      n = 0;
      for (int k = 1; k <= 60 && n < 10; k++) begin
         @(negedge clk);
         if (if_ready || dm_ready) begin
`ifdef ARB_FAIRNESS_EN
            exp_d = (n % (MS + 1)) != MS;
`else
            exp_d = 1'b1;
`endif
            chk("fair_order", 32'(dm_ready), 32'(exp_d));
            chk("fair_time", 32'(k), 32'(4 * n + 3));
            n++;
         end
      end
      chk("fair_count", 32'(n), 32'd10);
      dm_req = 1'b0; if_req = 1'b0;
      repeat (6) @(negedge clk);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      act = 1'b0; if_p = 1'b0; dm_p = 1'b0; e_if = 32'h0; e_dm = 32'h0; e_own = 1'b0;
      next_free = 0; starve = 0; g_cyc = 0; g_d = 1'b0; g_we = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rdy = act && c == g_cyc + LAT + 2;
         if (rdy && !(g_d && g_we)) begin
            if (g_d) e_dm = g_rd;
            else e_if = g_rd;
         end
         chk("rnd_if_ready", 32'(if_ready), 32'(rdy && !g_d));
         chk("rnd_dm_ready", 32'(dm_ready), 32'(rdy && g_d));
         chk("rnd_if_rdata", if_rdata, e_if);
         chk("rnd_dm_rdata", dm_rdata, e_dm);
         chk("rnd_mem_en", 32'(mem_en), 32'(act && c == g_cyc + 1));
         if (act && c == g_cyc + 1) begin
            chk("rnd_mem_addr", 32'(mem_addr), 32'(g_addr));
            chk("rnd_mem_we", 32'(mem_we), 32'(g_we));
            chk("rnd_mem_be", 32'(mem_be), g_we ? 32'(g_be) : 32'hF);
            if (g_we) chk("rnd_mem_wdata", mem_wdata, g_wdata);
         end
         chk("rnd_busy", 32'(busy), 32'(act && c > g_cyc && c <= g_cyc + LAT + 2));
         chk("rnd_owner", 32'(owner), 32'(e_own));
         if (rdy) begin
            act = 1'b0;
            if (g_d) begin dm_req = 1'b0; dm_p = 1'b0; end
            else begin if_req = 1'b0; if_p = 1'b0; end
         end
         if (!if_p && $urandom_range(0, 3) == 0) begin
            if_p = 1'b1; if_req = 1'b1; if_addr = 12'($urandom_range(0, 255));
         end
         if (!dm_p && $urandom_range(0, 2) == 0) begin
            dm_p = 1'b1; dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_be = 4'($urandom);
            dm_addr = 12'($urandom_range(0, 255)); dm_wdata = $urandom;
         end
         if (!act && c >= next_free && (if_req || dm_req)) begin
`ifdef ARB_FAIRNESS_EN
            force_f = if_req && starve == MS;
`else
            force_f = 1'b0;
`endif
            g_d = dm_req && !force_f;
            starve = g_d ? starve + (if_req ? 1 : 0) : 0;
            act = 1'b1; g_cyc = c; next_free = c + LAT + 3; e_own = g_d;
            g_addr = g_d ? dm_addr[11:2] : if_addr[11:2];
            g_we = g_d && dm_we; g_be = dm_be; g_wdata = dm_wdata;
            if (g_we)
               for (int b = 0; b < 4; b++)
                  if (g_be[b]) ref_mem[g_addr][8*b +: 8] = g_wdata[8*b +: 8];
            g_rd = ref_mem[g_addr];
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-ported unified instruction/data memory and shares it between the CPU's fetch port (read-only) and data port (read/write, byte enables).
- Sits between the cpu core and the memory macro in the top level.
- Issues one memory transaction at a time, waits a fixed memory latency, then returns read data with a one-cycle ready pulse to the winning requester.

Parameters:
- AW, 12, byte-address width of both requester ports.
- MEM_LAT, 1, memory read latency in clocks (legal range 1..15).
- MAX_STARVE, 4, consecutive data grants before fetch is forced (fairness build only, legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  AW  fetch byte address.
- if_rdata  out  32  fetched word.
- if_ready  out  1  one-cycle pulse; if_rdata valid in this cycle.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_be  in  4  write byte enables.
- dm_addr  in  AW  data byte address.
- dm_wdata  in  32  write data.
- dm_rdata  out  32  read data.
- dm_ready  out  1  one-cycle completion pulse (reads and writes).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_be  out  4  memory byte enables.
- mem_addr  out  AW-2  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT clocks after the mem_en edge.
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = fetch, 1 = data; last/current grant.

Behaviour:
- Reset: state IDLE. All outputs 0, including rdata registers, mem_* signals and owner. Starve counter 0.
- All outputs are registered.
- IDLE:
  - dm_req=1 grants data (owner=1); otherwise if_req=1 grants fetch (owner=0); otherwise stay in IDLE.
  - Both requests in the same cycle: data wins (see Optional Feature).
  - On grant, capture the address into mem_addr. mem_addr = addr[AW-1:2]; addr[1:0] is ignored, so misaligned accesses are word-aligned.
  - On a data grant, also capture dm_wdata and dm_we. Go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1.
  - mem_we=dm_we for data grants, 0 for fetch grants.
  - mem_be=dm_be for writes, 4'hF for reads.
  - Load latency counter with MEM_LAT-1. Go to WAIT.
- Outside ISSUE: mem_en=0, mem_we=0, mem_be=0. mem_addr and mem_wdata hold their last values.
- WAIT (MEM_LAT cycles):
  - Counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
  - Writes leave dm_rdata unchanged.
- DONE (1 cycle): the owner's ready=1, then go to IDLE.
  - Requests are not sampled in DONE, so the minimum gap between transactions is one IDLE cycle.
- Latency: the request sampled in IDLE at cycle 0 produces ready at cycle MEM_LAT+2.
- Request handling:
  - A requester deasserting req before ready is a protocol violation; the transaction completes anyway and ready still pulses.
  - The non-owner's ready stays 0 throughout.
- Write with dm_be=0: the full cycle is performed with mem_we=1, mem_be=0, and dm_ready still pulses.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No ready pulse; the transaction is abandoned.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined:
  - The starve counter increments on each data grant made while if_req=1, and clears on any fetch grant.
  - When the counter equals MAX_STARVE and if_req=1 in IDLE, fetch is granted even if dm_req=1, and the counter clears.
- Undefined: strict data priority; no counter logic is present.

Test Plan:
- Read, MEM_LAT=1: fetch read at 0x010 with mem_rdata=0x00000013 -> mem_en high at cycle 1 with mem_addr=0x004; if_ready at cycle 3 with if_rdata=0x00000013; busy high for cycles 1-3.
- Write: data write at 0x024, dm_be=4'b0011, dm_wdata=0xDEADBEEF -> one ISSUE cycle with mem_we=1, mem_be=0x3, mem_addr=0x009; dm_ready pulses; dm_rdata unchanged.
- Simultaneous requests: if_req and dm_req both asserted -> data served first (owner=1), then fetch; if_ready arrives 4 cycles after dm_ready (MEM_LAT=1).
- MEM_LAT=3: a read issues mem_en at cycle 1 -> ready at cycle 5; mem_rdata captured only at the last WAIT cycle.
- Mid-transaction reset: rst pulsed during WAIT -> state IDLE, all outputs 0, no ready pulse; a new fetch after reset completes normally.
- Fairness, MAX_STARVE=4, ARB_FAIRNESS_EN defined: dm_req and if_req held high -> 4 data grants, then 1 fetch grant, repeating. With the macro undefined -> fetch never granted.
